bcd_keypad_calc: RTL and testbench



---
 rtl/bcd_keypad_calc_if.sv | 36 +++
 rtl/bcd_keypad_calc.sv | 250 +++++++++++++++++++++++++
 tb/tb_bcd_keypad_calc.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_keypad_calc_if.sv
// Keypad/display bus for bcd_keypad_calc.
// BCD_CALC_SEG_EN adds the registered seven-segment output SEG.
interface bcd_keypad_calc_if #(
    parameter int unsigned DIGITS = 2
);
    logic [9:0]              KEY;
    logic                    START;
    logic                    OP;
    logic                    Addn_Sub;
    logic                    EQUAL;
    logic [4*(DIGITS+1)-1:0] DISP;
    logic                    NEG;
    logic                    BUSY;
    logic                    DONE;
`ifdef BCD_CALC_SEG_EN
    logic [7*(DIGITS+1)-1:0] SEG;

    modport master (
        output KEY, START, OP, Addn_Sub, EQUAL,
        input  DISP, NEG, BUSY, DONE, SEG
    );
    modport slave (
        input  KEY, START, OP, Addn_Sub, EQUAL,
        output DISP, NEG, BUSY, DONE, SEG
    );
`else
    modport master (
        output KEY, START, OP, Addn_Sub, EQUAL,
        input  DISP, NEG, BUSY, DONE
    );
    modport slave (
        input  KEY, START, OP, Addn_Sub, EQUAL,
        output DISP, NEG, BUSY, DONE
    );
`endif
endinterface

// File: rtl/bcd_keypad_calc.sv
// Multi-digit BCD keypad calculator: A+B or |A-B| with sign, digit-serial engine.
// Optional seven-segment output enabled by defining BCD_CALC_SEG_EN.
module bcd_keypad_calc #(
    parameter int unsigned DIGITS = 2
) (
    input logic              CLK,
    input logic              nRST,
    bcd_keypad_calc_if.slave bus
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned RW = 4 * (DIGITS + 1);
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LastCnt = CW'(DIGITS);

    typedef enum logic [2:0] {StIdle, StEnterA, StEnterB, StCompute, StResult} state_t;

    logic [9:0] key_s1, key_s2, key_prev;
    logic       op_s1, op_s2, op_prev, eq_s1, eq_s2, eq_prev, start_s1, start_s2;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d;
    logic [RW-1:0]   res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d, sub_q, sub_d, cy_q, cy_d, done_q, done_d;

    logic [3:0] low_cnt, key_val, dig;
    logic       key_evt, op_evt, eq_evt, dig_c;
    logic [4:0] sum, diff;
    logic [RW-1:0] disp;

    // Input synchronisers plus edge-detect history flops
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            {key_s1, key_s2, key_prev} <= '0;
            {op_s1, op_s2, op_prev}    <= '0;
            {eq_s1, eq_s2, eq_prev}    <= '0;
            {start_s1, start_s2}       <= '0;
        end else begin
            key_s1   <= bus.KEY;
            key_s2   <= key_s1;
            key_prev <= key_s2;
            op_s1    <= bus.OP;
            op_s2    <= op_s1;
            op_prev  <= op_s2;
            eq_s1    <= bus.EQUAL;
            eq_s2    <= eq_s1;
            eq_prev  <= eq_s2;
            start_s1 <= bus.START;
            start_s2 <= start_s1;
        end
    end

    // Key event: some key fell and exactly one key is held low
    always_comb begin
        low_cnt = 4'd0;
        key_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (!key_s2[i]) begin
                low_cnt = low_cnt + 4'd1;
                key_val = 4'(i);
            end
        end
        key_evt = (|(key_prev & ~key_s2)) && (low_cnt == 4'd1);
        op_evt  = op_s2 & ~op_prev;
        eq_evt  = eq_s2 & ~eq_prev;
    end

    // One BCD digit of add or subtract on the LS digits of the operand shifters
    always_comb begin
        sum   = {1'b0, x_q[3:0]} + {1'b0, y_q[3:0]} + {4'd0, cy_q};
        diff  = {1'b0, x_q[3:0]} + 5'd10 - {1'b0, y_q[3:0]} - {4'd0, cy_q};
        dig   = 4'd0;
        dig_c = 1'b0;
        if (!sub_q) begin
            if (sum >= 5'd10) begin
                dig   = 4'(sum - 5'd10);
                dig_c = 1'b1;
            end else begin
                dig   = sum[3:0];
            end
        end else begin
            if (diff >= 5'd10) begin
                dig   = 4'(diff - 5'd10);
            end else begin
                dig   = diff[3:0];
                dig_c = 1'b1;
            end
        end
    end

    // Next-state and datapath updates; START low overrides everything
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sub_d   = sub_q;
        cy_d    = cy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: state_d = StEnterA;
            StEnterA: begin
                if (key_evt && cnt_q < LastCnt) begin
                    a_d   = (a_q << 4) | W'(key_val);
                    cnt_d = cnt_q + 1'b1;
                end else if (op_evt) begin
                    sub_d   = bus.Addn_Sub;
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = StEnterB;
                end
            end
            StEnterB: begin
                if (key_evt && cnt_q < LastCnt) begin
                    b_d   = (b_q << 4) | W'(key_val);
                    cnt_d = cnt_q + 1'b1;
                end else if (eq_evt) begin
                    // Packed BCD orders like plain binary, so a vector compare suffices
                    neg_d   = sub_q && (a_q < b_q);
                    x_d     = neg_d ? b_q : a_q;
                    y_d     = neg_d ? a_q : b_q;
                    res_d   = '0;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (cnt_q < LastCnt) begin
                    res_d = {dig, res_q[RW-1:4]};
                    x_d   = x_q >> 4;
                    y_d   = y_q >> 4;
                    cy_d  = dig_c;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Top digit: final carry for add; borrow is always 0 here for subtract
                    res_d   = {3'd0, cy_q & ~sub_q, res_q[RW-1:4]};
                    done_d  = 1'b1;
                    state_d = StResult;
                end
            end
            StResult: begin
                if (key_evt) begin
                    a_d     = W'(key_val);
                    b_d     = '0;
                    neg_d   = 1'b0;
                    cnt_d   = CW'(1);
                    state_d = StEnterA;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!start_s2) begin
            state_d = StIdle;
            a_d     = '0;
            b_d     = '0;
            x_d     = '0;
            y_d     = '0;
            res_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
            sub_d   = 1'b0;
            cy_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sub_q   <= 1'b0;
            cy_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sub_q   <= sub_d;
            cy_q    <= cy_d;
            done_q  <= done_d;
        end
    end

    // Display select; B stays visible during COMPUTE since it was the prior value
    always_comb begin
        unique case (state_q)
            StEnterA:             disp = {4'd0, a_q};
            StEnterB, StCompute:  disp = {4'd0, b_q};
            StResult:             disp = res_q;
            default:              disp = '0;
        endcase
    end

    assign bus.DISP = disp;
    assign bus.NEG  = neg_q;
    assign bus.BUSY = (state_q == StCompute);
    assign bus.DONE = done_q;

`ifdef BCD_CALC_SEG_EN
    logic [7*(DIGITS+1)-1:0] seg_q;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Active-low segment patterns, one cycle behind DISP, blank in IDLE
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            seg_q <= '1;
        end else if (state_q == StIdle) begin
            seg_q <= '1;
        end else begin
            for (int i = 0; i <= int'(DIGITS); i++) begin
                seg_q[7*i +: 7] <= seg7(disp[4*i +: 4]);
            end
        end
    end

    assign bus.SEG = seg_q;
`endif
endmodule

// File: tb/tb_bcd_keypad_calc.sv
// Scoreboard bench for bcd_keypad_calc (DIGITS = 2).
module tb_bcd_keypad_calc;
    localparam int unsigned DIGITS = 2;

    typedef struct {
        logic [11:0] disp;
        logic        neg;
    } exp_t;

    logic CLK;
    logic nRST;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    bcd_keypad_calc_if #(.DIGITS(DIGITS)) bus ();

    bcd_keypad_calc #(.DIGITS(DIGITS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input int d);
        bus.KEY = ~(10'(1) << d);
        cyc(5);
        bus.KEY = '1;
        cyc(5);
    endtask

    task automatic op_key(input logic sub);
        bus.Addn_Sub = sub;
        bus.OP = 1'b1;
        cyc(5);
        bus.OP = 1'b0;
        cyc(5);
    endtask

    // Push the expected result, fire EQUAL, and wait (bounded) for DONE
    task automatic calc(input logic [11:0] disp, input logic neg);
        exp_t e;
        bit   seen;
        e.disp = disp;
        e.neg  = neg;
        sb.push_back(e);
        bus.EQUAL = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            if (bus.DONE) seen = 1'b1;
        end
        bus.EQUAL = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no DONE expected DONE within 30 cycles");
        end
        cyc(3);
    endtask

    // Monitor: compare each DONE against the scoreboard and the BUSY run length
    initial begin
        int   busy_run;
        logic prev_done;
        exp_t e;
        busy_run  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge CLK);
            if (prev_done) check("done_width", {31'd0, bus.DONE}, 32'd0);
            if (bus.DONE) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE expected none (disp %0h)", bus.DISP);
                end else begin
                    e = sb.pop_front();
                    check("result_disp", {20'd0, bus.DISP}, {20'd0, e.disp});
                    check("result_neg", {31'd0, bus.NEG}, {31'd0, e.neg});
                    check("busy_cycles", busy_run, DIGITS + 1);
                    check("busy_at_done", {31'd0, bus.BUSY}, 32'd0);
                end
                busy_run = 0;
            end else if (bus.BUSY) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
            prev_done = bus.DONE;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        nRST         = 1'b0;
        bus.KEY      = '1;
        bus.START    = 1'b0;
        bus.OP       = 1'b0;
        bus.Addn_Sub = 1'b0;
        bus.EQUAL    = 1'b0;
        cyc(3);
        check("reset_disp", {20'd0, bus.DISP}, 32'd0);
        check("reset_neg", {31'd0, bus.NEG}, 32'd0);
        check("reset_busy", {31'd0, bus.BUSY}, 32'd0);
        check("reset_done", {31'd0, bus.DONE}, 32'd0);
`ifdef BCD_CALC_SEG_EN
        check("reset_seg", {11'd0, bus.SEG}, {11'd0, 21'h1FFFFF});
`endif
        nRST = 1'b1;
        bus.START = 1'b1;
        cyc(5);

        // 12 + 34
        press(1);
        press(2);
        check("entry_a_12", {20'd0, bus.DISP}, 32'h012);
        op_key(1'b0);
        check("entry_b_clear", {20'd0, bus.DISP}, 32'h000);
        press(3);
        press(4);
        check("entry_b_34", {20'd0, bus.DISP}, 32'h034);
        calc(12'h046, 1'b0);
`ifdef BCD_CALC_SEG_EN
        check("seg_046", {11'd0, bus.SEG}, {11'd0, 7'h40, 7'h19, 7'h02});
`endif

        // 07 - 45 -> -38
        press(0);
        check("result_key0", {20'd0, bus.DISP}, 32'h000);
        press(7);
        check("entry_a_07", {20'd0, bus.DISP}, 32'h007);
        op_key(1'b1);
        press(4);
        press(5);
        calc(12'h038, 1'b1);

        // 45 - 45 -> 0, positive
        press(4);
        press(5);
        op_key(1'b1);
        press(4);
        press(5);
        calc(12'h000, 1'b0);

        // 50 - 07 -> 43, borrow across digits
        press(5);
        press(0);
        op_key(1'b1);
        press(0);
        press(7);
        calc(12'h043, 1'b0);

        // 99 + 99 -> 198, third digit ignored on both operands
        press(9);
        press(9);
        press(3);
        check("third_digit_a", {20'd0, bus.DISP}, 32'h099);
        op_key(1'b0);
        press(9);
        press(9);
        press(1);
        check("third_digit_b", {20'd0, bus.DISP}, 32'h099);
        calc(12'h198, 1'b0);

        // Digit in RESULT restarts entry; two keys at once are dropped
        press(6);
        check("result_key6", {20'd0, bus.DISP}, 32'h006);
        check("result_key6_neg", {31'd0, bus.NEG}, 32'd0);
        bus.KEY = ~((10'(1) << 3) | (10'(1) << 5));
        cyc(5);
        bus.KEY = '1;
        cyc(5);
        check("multi_key", {20'd0, bus.DISP}, 32'h006);
        press(1);
        check("entry_a_61", {20'd0, bus.DISP}, 32'h061);
        op_key(1'b0);
        press(2);
        check("entry_b_02", {20'd0, bus.DISP}, 32'h002);

        // START dropped one cycle after EQUAL: lands mid-COMPUTE, no DONE
        bus.EQUAL = 1'b1;
        cyc(1);
        bus.START = 1'b0;
        cyc(20);
        bus.EQUAL = 1'b0;
        check("abort_disp", {20'd0, bus.DISP}, 32'h000);
        check("abort_busy", {31'd0, bus.BUSY}, 32'd0);
        check("abort_neg", {31'd0, bus.NEG}, 32'd0);

        // Asynchronous reset mid-entry
        bus.START = 1'b1;
        cyc(5);
        press(5);
        press(3);
        check("entry_a_53", {20'd0, bus.DISP}, 32'h053);
        #2;
        nRST = 1'b0;
        #1;
        check("async_rst_disp", {20'd0, bus.DISP}, 32'h000);
        check("async_rst_neg", {31'd0, bus.NEG}, 32'd0);
        check("async_rst_busy", {31'd0, bus.BUSY}, 32'd0);
        check("async_rst_done", {31'd0, bus.DONE}, 32'd0);
        cyc(2);
        nRST = 1'b1;
        cyc(5);
        press(8);
        check("post_rst_entry", {20'd0, bus.DISP}, 32'h008);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
